stack_engine: RTL and testbench

Stack-operation sequencer that sits directly upstream of the ESP register. It accepts PUSH, POP and ESP-adjust requests from the decode/execute stage and performs the stack memory access over a req/ack handshake. It then commits the updated stack pointer to the ESP register by driving its 4-bit command (4'h2 = write) and write data. It is the only writer of ESP, and it enforces the stack window limits.

---
 rtl/stack_engine_if.sv | 32 +++
 rtl/stack_engine.sv | 148 ++++++++++++++
 tb/tb_stack_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/stack_engine_if.sv
// Bundles the op request, ESP register, memory and result signals of stack_engine.
// The master modport is the engine side; slave is the decode/ESP/memory environment.
interface stack_engine_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_data;
  logic        op_ready;
  logic [31:0] esp;
  logic [3:0]  esp_cmd;
  logic [31:0] esp_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic [31:0] res_data;
  logic        err;

  modport master (
    input  op_valid, op_code, op_data, esp, mem_ack, mem_rdata,
    output op_ready, esp_cmd, esp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
           res_valid, res_data, err
  );

  modport slave (
    output op_valid, op_code, op_data, esp, mem_ack, mem_rdata,
    input  op_ready, esp_cmd, esp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
           res_valid, res_data, err
  );
endinterface

// File: rtl/stack_engine.sv
// PUSH/POP/ADJ sequencer and sole ESP writer; ESP write at +1 (ADJ) or +2+waits (PUSH/POP).
// Accepts one op only in IDLE (op_ready); mem_req is held until mem_ack, no op queueing.
module stack_engine #(
  parameter logic [31:0] STACK_TOP   = 32'h000fffff,
  parameter logic [31:0] STACK_LIMIT = 32'h000f0000
) (
  input logic           clk1,
  input logic           reset,
  stack_engine_if.master bus
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_ADJ  = 2'b10;
  localparam logic [3:0] CMD_WR  = 4'h2;

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_COMMIT, ST_ERR} state_e;

  state_e      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] data_q, data_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] nval_q, nval_d;
  logic [31:0] res_data_q, res_data_d;
  logic        op_ready_q, op_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  esp_cmd_q, esp_cmd_d;
  logic [31:0] esp_wdata_q, esp_wdata_d;
  logic        res_valid_q, res_valid_d;
  logic        err_q, err_d;

  logic [32:0] s33;
  logic [33:0] adj_sum;
  logic        push_err, pop_err, adj_err;

  // Two guard bits keep the ADJ sum exact for any S and offset; a negative
  // result has bit 33 set and so fails the upper-bound compare as well.
  assign s33      = {1'b0, bus.esp};
  assign adj_sum  = {2'b00, bus.esp} + {{2{bus.op_data[31]}}, bus.op_data};
  assign push_err = s33 < ({1'b0, STACK_LIMIT} + 33'd4);
  assign pop_err  = (s33 + 33'd4) > {1'b0, STACK_TOP};
  assign adj_err  = (adj_sum < {2'b00, STACK_LIMIT}) || (adj_sum > {2'b00, STACK_TOP});

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    data_d     = data_q;
    snap_d     = snap_q;
    nval_d     = nval_q;
    res_data_d = res_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          code_d = bus.op_code;
          data_d = bus.op_data;
          snap_d = bus.esp;
          unique case (bus.op_code)
            OP_PUSH: begin
              nval_d  = bus.esp - 32'd4;
              state_d = push_err ? ST_ERR : ST_MEM;
            end
            OP_POP: begin
              nval_d  = bus.esp + 32'd4;
              state_d = pop_err ? ST_ERR : ST_MEM;
            end
            OP_ADJ: begin
              nval_d  = adj_sum[31:0];
              state_d = adj_err ? ST_ERR : ST_COMMIT;
            end
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          if (code_q == OP_POP) res_data_d = bus.mem_rdata;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered: derive next-cycle values from the next state.
    op_ready_d  = (state_d == ST_IDLE);
    mem_req_d   = (state_d == ST_MEM);
    mem_we_d    = (state_d == ST_MEM) && (code_d == OP_PUSH);
    mem_addr_d  = (state_d != ST_MEM) ? 32'd0 : ((code_d == OP_PUSH) ? nval_d : snap_d);
    mem_wdata_d = mem_we_d ? data_d : 32'd0;
    esp_cmd_d   = (state_d == ST_COMMIT) ? CMD_WR : 4'h0;
    esp_wdata_d = (state_d == ST_COMMIT) ? nval_d : 32'd0;
    res_valid_d = (state_d == ST_COMMIT) && (code_d == OP_POP);
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      code_q      <= 2'b00;
      data_q      <= 32'd0;
      snap_q      <= 32'd0;
      nval_q      <= 32'd0;
      res_data_q  <= 32'd0;
      op_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      esp_cmd_q   <= 4'h0;
      esp_wdata_q <= 32'd0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      data_q      <= data_d;
      snap_q      <= snap_d;
      nval_q      <= nval_d;
      res_data_q  <= res_data_d;
      op_ready_q  <= op_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      esp_cmd_q   <= esp_cmd_d;
      esp_wdata_q <= esp_wdata_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.esp_cmd   = esp_cmd_q;
  assign bus.esp_wdata = esp_wdata_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine: hand-computed PUSH/POP/ADJ, error and reset cases.
module tb_stack_engine;
  logic clk1 = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  stack_engine_if bus();

  stack_engine u_dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Present an op for one edge; returns in cycle +1.
  task automatic send_op(input logic [1:0] code, input logic [31:0] data, input logic [31:0] espv);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_data  = data;
    bus.esp      = espv;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic err_op(input string tag, input logic [1:0] code, input logic [31:0] data,
                        input logic [31:0] espv);
    send_op(code, data, espv);
    chk({tag, "_err"},     32'(bus.err), 32'd1);
    chk({tag, "_nomem"},   32'(bus.mem_req), 32'd0);
    chk({tag, "_noesp"},   32'(bus.esp_cmd), 32'd0);
    chk({tag, "_busy"},    32'(bus.op_ready), 32'd0);
    tick();
    chk({tag, "_errdrop"}, 32'(bus.err), 32'd0);
    chk({tag, "_ready"},   32'(bus.op_ready), 32'd1);
  endtask

  task automatic push_fast(input string tag, input logic [31:0] data, input logic [31:0] espv,
                           input logic [31:0] exp_n);
    send_op(2'b00, data, espv);
    chk({tag, "_req"},   32'(bus.mem_req), 32'd1);
    chk({tag, "_we"},    32'(bus.mem_we), 32'd1);
    chk({tag, "_addr"},  bus.mem_addr, exp_n);
    chk({tag, "_wdata"}, bus.mem_wdata, data);
    chk({tag, "_busy"},  32'(bus.op_ready), 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk({tag, "_cmd"},   32'(bus.esp_cmd), 32'h2);
    chk({tag, "_wesp"},  bus.esp_wdata, exp_n);
    chk({tag, "_reqoff"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_nores"}, 32'(bus.res_valid), 32'd0);
    tick();
    chk({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
    chk({tag, "_cmdoff"}, 32'(bus.esp_cmd), 32'd0);
    chk({tag, "_wespoff"}, bus.esp_wdata, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_code   = 2'b00;
    bus.op_data   = 32'd0;
    bus.esp       = 32'h000fffff;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    #2;
    chk("rst_ready",   32'(bus.op_ready), 32'd1);
    chk("rst_req",     32'(bus.mem_req), 32'd0);
    chk("rst_cmd",     32'(bus.esp_cmd), 32'd0);
    chk("rst_err",     32'(bus.err), 32'd0);
    chk("rst_resdata", bus.res_data, 32'd0);
    chk("rst_addr",    bus.mem_addr, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(bus.op_ready), 32'd1);

    push_fast("push1", 32'hdeadbeef, 32'h000fffff, 32'h000ffffb);

    // POP with three wait cycles; an op offered while busy must be dropped.
    send_op(2'b01, 32'd0, 32'h000ffffb);
    for (int i = 0; i < 4; i++) begin
      chk("pop_req",  32'(bus.mem_req), 32'd1);
      chk("pop_we",   32'(bus.mem_we), 32'd0);
      chk("pop_addr", bus.mem_addr, 32'h000ffffb);
      bus.op_valid = (i < 2);
      bus.op_code  = 2'b10;
      bus.op_data  = 32'h00000004;
      if (i == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
      end
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    chk("pop_resv",  32'(bus.res_valid), 32'd1);
    chk("pop_res",   bus.res_data, 32'h12345678);
    chk("pop_cmd",   32'(bus.esp_cmd), 32'h2);
    chk("pop_wesp",  bus.esp_wdata, 32'h000fffff);
    tick();
    chk("pop_resv0", 32'(bus.res_valid), 32'd0);
    chk("pop_hold",  bus.res_data, 32'h12345678);
    chk("pop_ready", 32'(bus.op_ready), 32'd1);
    tick();
    chk("noqueue_cmd", 32'(bus.esp_cmd), 32'd0);
    chk("noqueue_req", 32'(bus.mem_req), 32'd0);

    err_op("pop_under",  2'b01, 32'd0, 32'h000fffff);
    err_op("push_over",  2'b00, 32'h1, 32'h000f0003);
    push_fast("push_lim", 32'h0badcafe, 32'h000f0004, 32'h000f0000);

    send_op(2'b10, 32'hfffffff0, 32'h000fffff);
    chk("adj_cmd",   32'(bus.esp_cmd), 32'h2);
    chk("adj_wesp",  bus.esp_wdata, 32'h000fffef);
    chk("adj_nomem", 32'(bus.mem_req), 32'd0);
    tick();
    chk("adj_ready", 32'(bus.op_ready), 32'd1);

    send_op(2'b10, 32'hfffffff0, 32'h000f0010);
    chk("adjlim_wesp", bus.esp_wdata, 32'h000f0000);
    tick();

    err_op("adj_hi",   2'b10, 32'h00000010, 32'h000fffff);
    err_op("adj_lo",   2'b10, 32'hfffffffc, 32'h000f0000);
    err_op("reserved", 2'b11, 32'd0, 32'h000ffff0);

    // Reset in the middle of a memory wait.
    send_op(2'b00, 32'h000000a5, 32'h000fffff);
    chk("rmem_req", 32'(bus.mem_req), 32'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rmem_reqdrop", 32'(bus.mem_req), 32'd0);
    chk("rmem_ready",   32'(bus.op_ready), 32'd1);
    chk("rmem_addr",    bus.mem_addr, 32'd0);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("rmem_nocmd",  32'(bus.esp_cmd), 32'd0);
    tick();
    chk("rmem_nocmd2", 32'(bus.esp_cmd), 32'd0);
    chk("rmem_idle",   32'(bus.op_ready), 32'd1);

    push_fast("push_after", 32'h00000055, 32'h000fffff, 32'h000ffffb);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
